// File: rtl/seq_mag_comparator_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states,
// result encoding and a printable label for each result.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_GT = 2'd0,
    RES_LT = 2'd1,
    RES_EQ = 2'd2
  } result_t;

  // Three ASCII characters packed into 24 bits, suitable for %s printing.
  function automatic logic [23:0] result_str(input result_t r);
    logic [23:0] s;
    case (r)
      RES_GT:  s = "A>B";
      RES_LT:  s = "A<B";
      default: s = "A=B";
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Request/response bundle of the comparator. The producer drives the
// operands, the consumer drives out_ready; the comparator is the slave.
interface seq_mag_comparator_if #(
  parameter int W  = 16,
  parameter int CW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          signed_mode;
  logic          out_valid;
  logic          out_ready;
  logic          gt;
  logic          lt;
  logic          eq;
  logic [CW-1:0] out_cycles;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, gt, lt, eq, out_cycles
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, gt, lt, eq, out_cycles
  );
endinterface

// File: rtl/seq_mag_comparator_chunk_cmp.sv
// Unsigned compare of one CHUNK-bit slice of each operand.
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] ca,
  input  logic [CHUNK-1:0] cb,
  output logic             c_gt,
  output logic             c_lt
);

  assign c_gt = (ca > cb);
  assign c_lt = (ca < cb);

endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator. Operands are scanned MSB chunk first and
// the scan stops at the first chunk that differs. Signed compares are turned
// into unsigned ones by flipping the operand sign bits when they are latched.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int W     = 16,
  parameter int CHUNK = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_mag_comparator_if.slave bus
);

  localparam int NCHUNK = W / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [W-1:0] MSB_MASK = W'(1) << (W - 1);

  if (CHUNK < 1 || W < CHUNK || (W % CHUNK) != 0) begin : g_param_check
    $fatal(1, "seq_mag_comparator: W must be a non-zero multiple of CHUNK");
  end

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;
  logic            out_valid_q;
  logic            gt_q;
  logic            lt_q;
  logic            eq_q;
  logic [CW-1:0]   cycles_q;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic            c_gt;
  logic            c_lt;

  assign ca = a_q[idx*CHUNK +: CHUNK];
  assign cb = b_q[idx*CHUNK +: CHUNK];

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .ca   (ca),
    .cb   (cb),
    .c_gt (c_gt),
    .c_lt (c_lt)
  );

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.gt         = gt_q;
  assign bus.lt         = lt_q;
  assign bus.eq         = eq_q;
  assign bus.out_cycles = cycles_q;

  // Accept, scan one chunk per cycle until resolved, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      cycles_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a ^ (bus.signed_mode ? MSB_MASK : '0);
            b_q   <= bus.b ^ (bus.signed_mode ? MSB_MASK : '0);
            idx   <= IW'(NCHUNK - 1);
            cnt   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          cnt <= cnt + 1'b1;
          if (c_gt) begin
            gt_q        <= 1'b1;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            cycles_q    <= cnt + 1'b1;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else if (c_lt) begin
            gt_q        <= 1'b0;
            lt_q        <= 1'b1;
            eq_q        <= 1'b0;
            cycles_q    <= cnt + 1'b1;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else if (idx == '0) begin
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b1;
            cycles_q    <= CW'(NCHUNK);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Self-checking bench: directed cases, backpressure, mid-scan reset and a
// randomized sweep over three width/chunk configurations against a
// numeric reference model.
module tb_seq_mag_comparator;
  import cmp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // cfg 0: W=16/CHUNK=4, cfg 1: W=8/CHUNK=1, cfg 2: W=12/CHUNK=12
  seq_mag_comparator_if #(.W(16), .CW(3)) bus16 ();
  seq_mag_comparator_if #(.W(8),  .CW(4)) bus8 ();
  seq_mag_comparator_if #(.W(12), .CW(1)) bus12 ();

  seq_mag_comparator #(.W(16), .CHUNK(4))  dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  seq_mag_comparator #(.W(8),  .CHUNK(1))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  seq_mag_comparator #(.W(12), .CHUNK(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12.slave));

  function automatic int cfg_w(input int cfg);
    return (cfg == 0) ? 16 : (cfg == 1) ? 8 : 12;
  endfunction

  function automatic int cfg_chunk(input int cfg);
    return (cfg == 0) ? 4 : (cfg == 1) ? 1 : 12;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int cfg, input logic v, input logic [15:0] av,
                         input logic [15:0] bv, input logic sm);
    case (cfg)
      0: begin bus16.in_valid = v; bus16.a = av;        bus16.b = bv;        bus16.signed_mode = sm; end
      1: begin bus8.in_valid  = v; bus8.a  = av[7:0];   bus8.b  = bv[7:0];   bus8.signed_mode  = sm; end
      default: begin bus12.in_valid = v; bus12.a = av[11:0]; bus12.b = bv[11:0]; bus12.signed_mode = sm; end
    endcase
  endtask

  task automatic set_ready(input int cfg, input logic v);
    case (cfg)
      0: bus16.out_ready = v;
      1: bus8.out_ready = v;
      default: bus12.out_ready = v;
    endcase
  endtask

  // {in_ready, out_valid, gt, lt, eq}
  function automatic logic [4:0] rd_status(input int cfg);
    case (cfg)
      0: return {bus16.in_ready, bus16.out_valid, bus16.gt, bus16.lt, bus16.eq};
      1: return {bus8.in_ready, bus8.out_valid, bus8.gt, bus8.lt, bus8.eq};
      default: return {bus12.in_ready, bus12.out_valid, bus12.gt, bus12.lt, bus12.eq};
    endcase
  endfunction

  function automatic logic [31:0] rd_cycles(input int cfg);
    case (cfg)
      0: return 32'(bus16.out_cycles);
      1: return 32'(bus8.out_cycles);
      default: return 32'(bus12.out_cycles);
    endcase
  endfunction

  function automatic result_t flags_to_res(input logic [2:0] f);
    return (f == 3'b100) ? RES_GT : (f == 3'b010) ? RES_LT : RES_EQ;
  endfunction

  // Reference: numeric compare of the (optionally sign-extended) values;
  // chunks examined follows from the highest differing bit position.
  task automatic ref_model(input int cfg, input logic [15:0] av, input logic [15:0] bv,
                           input logic sm, output logic [2:0] flags, output int cyc);
    int w;
    int ch;
    longint mask;
    longint va;
    longint vb;
    longint diff;
    int p;
    w    = cfg_w(cfg);
    ch   = cfg_chunk(cfg);
    mask = (longint'(1) << w) - 1;
    va   = longint'(av) & mask;
    vb   = longint'(bv) & mask;
    if (sm && va[w-1]) va = va - (longint'(1) << w);
    if (sm && vb[w-1]) vb = vb - (longint'(1) << w);
    flags = (va > vb) ? 3'b100 : (va < vb) ? 3'b010 : 3'b001;
    diff = (longint'(av) ^ longint'(bv)) & mask;
    p = -1;
    for (int i = 0; i < w; i++) if (diff[i]) p = i;
    cyc = (p < 0) ? (w / ch) : (w / ch - p / ch);
  endtask

  // Present one request; returns just after the accepting edge.
  task automatic applyStimulus(input int cfg, input logic [15:0] av, input logic [15:0] bv,
                               input logic sm);
    @(negedge clk);
    set_req(cfg, 1'b1, av, bv, sm);
    @(posedge clk);
    #1;
    set_req(cfg, 1'b0, av, bv, sm);
  endtask

  task automatic wait_result(input int cfg, output int lat);
    logic [4:0] st;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      st = rd_status(cfg);
    end while (!st[3] && lat < 40);
    if (!st[3]) checkOutput("timeout", 32'd0, 32'd1);
  endtask

  task automatic release_result(input int cfg);
    logic [4:0] st;
    set_ready(cfg, 1'b1);
    @(posedge clk);
    #1;
    set_ready(cfg, 1'b0);
    st = rd_status(cfg);
    checkOutput("valid_drop", 32'(st[3]), 32'd0);
    checkOutput("ready_back", 32'(st[4]), 32'd1);
  endtask

  task automatic run_and_check(input int cfg, input logic [15:0] av, input logic [15:0] bv,
                               input logic sm, input logic [2:0] exp_flags, input int exp_cyc,
                               input string tag);
    int lat;
    logic [4:0] st;
    applyStimulus(cfg, av, bv, sm);
    wait_result(cfg, lat);
    st = rd_status(cfg);
    checkOutput({tag, "_flags"}, 32'(st[2:0]), 32'(exp_flags));
    checkOutput({tag, "_cycles"}, rd_cycles(cfg), 32'(exp_cyc));
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_cyc));
    checkOutput({tag, "_in_ready_busy"}, 32'(st[4]), 32'd0);
    release_result(cfg);
  endtask

  initial begin
    logic [4:0] st;
    logic [2:0] ef;
    int ec;
    int lat;
    logic [15:0] av;
    logic [15:0] bv;
    int w;

    for (int c = 0; c < 3; c++) begin
      set_req(c, 1'b0, 16'h0, 16'h0, 1'b0);
      set_ready(c, 1'b0);
    end

    // Reset state
    #12;
    st = rd_status(0);
    checkOutput("reset_status", 32'(st), 32'(5'b10000));
    checkOutput("reset_cycles", rd_cycles(0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_and_check(0, 16'h8000, 16'h7FFF, 1'b0, 3'b100, 1, "u_8000_7fff");
    run_and_check(0, 16'h8000, 16'h7FFF, 1'b1, 3'b010, 1, "s_8000_7fff");
    run_and_check(0, 16'hFFFF, 16'h0000, 1'b1, 3'b010, 1, "s_ffff_0000");
    run_and_check(0, 16'h1234, 16'h1234, 1'b0, 3'b001, 4, "eq_1234");
    run_and_check(0, 16'h1235, 16'h1234, 1'b0, 3'b100, 4, "gt_1235");
    run_and_check(0, 16'h0F00, 16'h0E00, 1'b0, 3'b100, 2, "gt_0f00");
    run_and_check(1, 16'h0080, 16'h0001, 1'b1, 3'b010, 1, "w8_signed");
    run_and_check(2, 16'h0123, 16'h0123, 1'b0, 3'b001, 1, "w12_eq");
    $display("[TB] directed phase complete, last label %s", result_str(flags_to_res(3'b001)));

    // Backpressure: hold the result, pulse in_valid while held
    applyStimulus(0, 16'h0005, 16'h0003, 1'b0);
    wait_result(0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_req(0, (i == 2), 16'h0000, 16'hFFFF, 1'b0);
      @(posedge clk);
      #1;
      set_req(0, 1'b0, 16'h0000, 16'hFFFF, 1'b0);
      st = rd_status(0);
      checkOutput("bp_status", 32'(st), 32'(5'b01100));
      checkOutput("bp_cycles", rd_cycles(0), 32'd4);
    end
    release_result(0);
    repeat (3) @(posedge clk);
    #1;
    st = rd_status(0);
    checkOutput("bp_pulse_dropped", 32'(st[4:3]), 32'(2'b10));
    run_and_check(0, 16'hA000, 16'h9FFF, 1'b0, 3'b100, 1, "after_bp");

    // Reset in the middle of an equal-operand scan
    applyStimulus(0, 16'h1234, 16'h1234, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    st = rd_status(0);
    checkOutput("midreset_status", 32'(st), 32'(5'b10000));
    checkOutput("midreset_cycles", rd_cycles(0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    st = rd_status(0);
    checkOutput("post_reset_idle", 32'(st[4:3]), 32'(2'b10));
    run_and_check(0, 16'h0003, 16'h0005, 1'b0, 3'b010, 4, "after_reset");

    // Random sweep against the reference model
    for (int c = 0; c < 3; c++) begin
      w = cfg_w(c);
      for (int sm = 0; sm < 2; sm++) begin
        for (int i = 0; i < ((c == 0) ? 1000 : 250); i++) begin
          av = 16'($urandom);
          case ($urandom_range(0, 2))
            0: bv = 16'($urandom);
            1: bv = av;
            default: bv = av ^ (16'd1 << $urandom_range(0, w - 1));
          endcase
          ref_model(c, av, bv, sm[0], ef, ec);
          run_and_check(c, av, bv, sm[0], ef, ec, "rand");
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
